// File: rtl/key_input_conditioner.sv
// key_input_conditioner: conditions raw active-low DE2 pushbuttons into clean
// per-key events on CLOCK_50.
// Ports:
//   CLOCK_50      system clock
//   RST           synchronous active-high reset
//   KEY_N         raw pushbuttons, active-low, asynchronous
//   key_level     debounced pressed level (1 = pressed)
//   press_pulse   1-cycle strobe on accepted press
//   release_pulse 1-cycle strobe on accepted release
//   long_pulse    1-cycle strobe once per press held LONG_CYCLES
//   last_key      index of the lowest key in the most recent press strobe
//   last_valid    set on the first press after reset
module key_input_conditioner #(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input  logic              CLOCK_50,
   input  logic              RST,
   input  logic [N_KEYS-1:0] KEY_N,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [2:0]        last_key,
   output logic              last_valid
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_LONG     = 2'd2
   } key_state_t;

   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] sync2;
   logic [N_KEYS-1:0] s;
   logic [N_KEYS-1:0] press_nx_v;
   logic [2:0]        low_idx;

   // Two-flop synchronizer; reset to released so a held key is re-debounced.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= KEY_N;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_state_t        state, state_nx;
      logic [DEB_W-1:0]  deb, deb_nx;
      logic [HOLD_W-1:0] hold, hold_nx;
      logic              level_q, press_q, release_q, long_q;
      logic              press_nx, release_nx, long_nx;

      // State, counters and registered event outputs.
      always_ff @(posedge CLOCK_50) begin
         if (RST) begin
            state     <= ST_RELEASED;
            deb       <= '0;
            hold      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            state     <= state_nx;
            deb       <= deb_nx;
            hold      <= hold_nx;
            level_q   <= (state_nx != ST_RELEASED);
            press_q   <= press_nx;
            release_q <= release_nx;
            long_q    <= long_nx;
         end
      end

      // Debounce / hold next-state logic.
      always_comb begin
         state_nx   = state;
         deb_nx     = deb;
         hold_nx    = hold;
         press_nx   = 1'b0;
         release_nx = 1'b0;
         long_nx    = 1'b0;
         unique case (state)
            ST_RELEASED: begin
               if (s[k]) begin
                  if (deb == DEB_MAX) begin
                     state_nx = ST_PRESSED;
                     press_nx = 1'b1;
                     deb_nx   = '0;
                     hold_nx  = '0;
                  end else begin
                     deb_nx = deb + DEB_W'(1);
                  end
               end else begin
                  deb_nx = '0;
               end
            end
            ST_PRESSED, ST_LONG: begin
               if (!s[k]) begin
                  if (deb == DEB_MAX) begin
                     state_nx   = ST_RELEASED;
                     release_nx = 1'b1;
                     deb_nx     = '0;
                  end else begin
                     deb_nx = deb + DEB_W'(1);
                  end
               end else begin
                  deb_nx = '0;
               end
               // A release accepted on the threshold cycle suppresses the long strobe.
               if (state == ST_PRESSED && !release_nx) begin
                  if (hold == HOLD_MAX) begin
                     long_nx  = 1'b1;
                     state_nx = ST_LONG;
                  end else begin
                     hold_nx = hold + HOLD_W'(1);
                  end
               end
            end
            default: state_nx = ST_RELEASED;
         endcase
      end

      assign key_level[k]     = level_q;
      assign press_pulse[k]   = press_q;
      assign release_pulse[k] = release_q;
      assign long_pulse[k]    = long_q;
      assign press_nx_v[k]    = press_nx;
   end

   // Lowest set bit of the press strobes about to be issued.
   always_comb begin
      low_idx = 3'd0;
      for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
         if (press_nx_v[i]) low_idx = 3'(i);
      end
   end

   // last_key updates in the same cycle its press_pulse is visible.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         last_key   <= 3'd0;
         last_valid <= 1'b0;
      end else if (|press_nx_v) begin
         last_key   <= low_idx;
         last_valid <= 1'b1;
      end
   end

endmodule
